// File: rtl/decoder_seq.sv
// Registered N-to-NUM_OUT decoder (one-hot or thermometer) with out-of-range flag.
// Optional auto-scan sequencer built when DECODER_SEQ_SCAN_EN is defined.
module decoder_seq #(
    parameter int unsigned N       = 3,
    parameter int unsigned NUM_OUT = 2**N,
    parameter int unsigned DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N-1:0]       w,
    input  logic               therm,
    input  logic               scan_start,
    input  logic               scan_stop,
    output logic [NUM_OUT-1:0] y,
    output logic               err,
    output logic               busy
);

    localparam int unsigned IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Thermometer is derived from the one-hot at NUM_OUT width so the top code wraps to all ones.
    function automatic logic [NUM_OUT-1:0] decode(input logic [N-1:0] code, input logic th);
        logic [NUM_OUT-1:0] one;
        one = NUM_OUT'(1) << code;
        return th ? ((one << 1) - NUM_OUT'(1)) : one;
    endfunction

    logic [NUM_OUT-1:0] y_q, y_d, y_w;
    logic               err_q, err_d, err_w;
    logic               busy_q, busy_d;
    logic               in_range;

    assign in_range = ({1'b0, w} < (N+1)'(NUM_OUT));
    assign y_w      = (en && in_range) ? decode(w, therm) : '0;
    assign err_w    = en && !in_range;

`ifdef DECODER_SEQ_SCAN_EN
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;

    // Next-state: w decode in IDLE, index decode in SCAN; en=0 freezes the scan.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        y_d     = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                y_d   = y_w;
                err_d = err_w;
                if (scan_start && !scan_stop) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    dwell_d = '0;
                end
            end
            SCAN: begin
                if (en) begin
                    if (scan_stop) begin
                        state_d = IDLE;
                        y_d     = y_w;
                        err_d   = err_w;
                    end else begin
                        y_d = decode(N'(idx_q), therm);
                        if (dwell_q == DW'(DWELL - 1)) begin
                            dwell_d = '0;
                            idx_d   = (idx_q == IW'(NUM_OUT - 1)) ? '0 : idx_q + IW'(1);
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end
`else
    logic unused_scan;
    assign unused_scan = scan_start ^ scan_stop;

    always_comb begin
        y_d    = y_w;
        err_d  = err_w;
        busy_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    assign y    = y_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: NUM_OUT=8 and NUM_OUT=6 instances, randomized decode and scan checks.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n, en, therm, scan_start, scan_stop;
    logic [2:0] w;
    logic [7:0] y;
    logic [5:0] y6;
    logic       err, err6, busy, busy6;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    decoder_seq #(.N(3), .NUM_OUT(8), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .w(w), .therm(therm),
        .scan_start(scan_start), .scan_stop(scan_stop),
        .y(y), .err(err), .busy(busy));

    decoder_seq #(.N(3), .NUM_OUT(6), .DWELL(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .w(w), .therm(therm),
        .scan_start(scan_start), .scan_stop(scan_stop),
        .y(y6), .err(err6), .busy(busy6));

    // Reference: select k -> 2^k (one-hot) or 2^(k+1)-1 (thermometer); zero if disabled or out of range.
    function automatic logic [7:0] exp_dec(int code, bit th, int nout, bit enb);
        if (!enb || code >= nout) return 8'h00;
        if (th) return 8'((1 << (code + 1)) - 1);
        return 8'(1 << code);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; w = 3'd3; therm = 1'b0; scan_start = 1'b0; scan_stop = 1'b0;
        #2;
        vectors++;
        if (y !== 8'h00 || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: y=%h err=%b busy=%b, required 00/0/0", y, err, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (y !== 8'h08 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: y=%h err=%b, required 08/0", y, err);
        end
    endtask

    task automatic test_onehot;
        therm = 1'b0; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = 3'(k);
            @(posedge clk); #1;
            vectors++;
            if (y !== exp_dec(k, 1'b0, 8, 1'b1) || err !== 1'b0) begin
                miscompares++;
                $display("FAIL onehot w=%0d: y=%h err=%b, required %h/0", k, y, err, exp_dec(k, 1'b0, 8, 1'b1));
            end
        end
    endtask

    task automatic test_therm;
        therm = 1'b1; en = 1'b1; w = 3'd5;
        @(posedge clk); #1;
        vectors++;
        if (y !== 8'h3F) begin
            miscompares++;
            $display("FAIL therm_w5: y=%h, required 3f", y);
        end
        w = 3'd7;
        @(posedge clk); #1;
        vectors++;
        if (y !== 8'hFF) begin
            miscompares++;
            $display("FAIL therm_w7: y=%h, required ff", y);
        end
    endtask

    task automatic test_range;
        logic [2:0] codes [3];
        codes[0] = 3'd6; codes[1] = 3'd7; codes[2] = 3'd2;
        therm = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = codes[i];
            @(posedge clk); #1;
            vectors++;
            if ({2'b00, y6} !== exp_dec(int'(codes[i]), 1'b0, 6, 1'b1) || err6 !== (codes[i] >= 3'd6)) begin
                miscompares++;
                $display("FAIL range6 w=%0d: y=%h err=%b, required %h/%b", codes[i], y6,
                         err6, exp_dec(int'(codes[i]), 1'b0, 6, 1'b1), codes[i] >= 3'd6);
            end
        end
    endtask

    task automatic test_random_decode;
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 3) != 0); w = 3'($urandom); therm = 1'($urandom);
            @(posedge clk); #1;
            vectors++;
            if (y !== exp_dec(int'(w), therm, 8, en) || err !== 1'b0 ||
                {2'b00, y6} !== exp_dec(int'(w), therm, 6, en) || err6 !== (en && w >= 3'd6)) begin
                miscompares++;
                $display("FAIL rand_decode en=%b w=%0d th=%b: y=%h y6=%h err6=%b, required %h %h %b",
                         en, w, therm, y, y6, err6, exp_dec(int'(w), therm, 8, en),
                         exp_dec(int'(w), therm, 6, en), en && w >= 3'd6);
            end
        end
    endtask

`ifdef DECODER_SEQ_SCAN_EN
    task automatic test_scan;
        int p = 0;
        int idx;
        en = 1'b1; therm = 1'b0; w = 3'd3; scan_start = 1'b1; scan_stop = 1'b0;
        @(posedge clk); #1;
        scan_start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || y !== 8'h08) begin
            miscompares++;
            $display("FAIL scan_enter: busy=%b y=%h, required 1/08", busy, y);
        end
        for (int c = 0; c < 44; c++) begin
            en = !(c >= 10 && c < 13);
            w = 3'($urandom); therm = (c < 30) ? 1'b0 : 1'($urandom);
            scan_start = (c == 20);
            @(posedge clk); #1;
            idx = (p / 4) % 8;
            vectors++;
            if (y !== exp_dec(idx, therm, 8, en) || busy !== 1'b1 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_cycle %0d: y=%h busy=%b err=%b, required %h/1/0",
                         c, y, busy, err, exp_dec(idx, therm, 8, en));
            end
            if (en) p++;
        end
        scan_start = 1'b0;
    endtask

    task automatic test_scan_stop;
        en = 1'b1; therm = 1'b0; w = 3'd5; scan_stop = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || y !== 8'h20) begin
            miscompares++;
            $display("FAIL scan_stop: busy=%b y=%h, required 0/20", busy, y);
        end
        scan_start = 1'b1; w = 3'd1;
        @(posedge clk); #1;
        scan_start = 1'b0; scan_stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || y !== 8'h02) begin
            miscompares++;
            $display("FAIL start_and_stop: busy=%b y=%h, required 0/02", busy, y);
        end
        w = 3'd6;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || y !== 8'h40) begin
            miscompares++;
            $display("FAIL idle_after_both: busy=%b y=%h, required 0/40", busy, y);
        end
    endtask

    task automatic test_reset_midscan;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || y !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_midscan: busy=%b y=%h, required 0/00", busy, y);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; w = 3'd4;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || y !== 8'h10) begin
            miscompares++;
            $display("FAIL after_reset_midscan: busy=%b y=%h, required 0/10", busy, y);
        end
    endtask
`else
    task automatic test_no_scan;
        for (int i = 0; i < 20; i++) begin
            en = 1'b1; w = 3'($urandom); therm = 1'($urandom);
            scan_start = (i % 5 == 0); scan_stop = (i % 7 == 3);
            @(posedge clk); #1;
            vectors++;
            if (busy !== 1'b0 || y !== exp_dec(int'(w), therm, 8, 1'b1)) begin
                miscompares++;
                $display("FAIL no_scan %0d: busy=%b y=%h, required 0/%h", i, busy, y,
                         exp_dec(int'(w), therm, 8, 1'b1));
            end
        end
        scan_start = 1'b0; scan_stop = 1'b0;
        w = 3'd7; therm = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_middecode: y=%h busy=%b, required 00/0", y, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_onehot();
        test_therm();
        test_range();
        test_random_decode();
`ifdef DECODER_SEQ_SCAN_EN
        test_scan();
        test_scan_stop();
        test_reset_midscan();
`else
        test_no_scan();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
